// File: rtl/mbledhesi_pkg.sv
// Shared definitions for the sequenced 48-bit add/subtract unit.
package mbledhesi_pkg;

  localparam int W_HALF_DEF = 24;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOW  = 2'd1,
    ST_HIGH = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  // Signed overflow: like-signed operands whose sum flips sign.
  function automatic logic ovf_bit(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/mbledhesi_48_sekuencial_adder.sv
// Mbledhesi24Bitesh: plain ripple-carry half-word adder shared by both passes.
module Mbledhesi24Bitesh #(
  parameter int W = 24
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         cin,
  output logic [W-1:0] sum,
  output logic         cout
);

  // Bit-serial carry chain, evaluated combinationally.
  always_comb begin
    logic c_v;
    sum  = '0;
    c_v  = cin;
    for (int i = 0; i < W; i++) begin
      sum[i] = a[i] ^ b[i] ^ c_v;
      c_v    = (a[i] & b[i]) | (c_v & (a[i] ^ b[i]));
    end
    cout = c_v;
  end

endmodule

// File: rtl/mbledhesi_48_sekuencial.sv
// Two-pass 48-bit add/subtract: one half-word adder reused for low then high half,
// with valid/ready handshakes on request and result.
module mbledhesi_48_sekuencial
  import mbledhesi_pkg::*;
#(
  parameter int W_HALF = W_HALF_DEF
) (
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  IN_VALID,
  output logic                  IN_READY,
  input  logic                  OP,
  input  logic [2*W_HALF-1:0]   A,
  input  logic [2*W_HALF-1:0]   B,
  input  logic                  CIN,
  output logic                  OUT_VALID,
  input  logic                  OUT_READY,
  output logic [2*W_HALF-1:0]   Shuma,
  output logic                  CarryOut,
  output logic                  Overflow,
  output logic                  Zero
);

  localparam int W_FULL = 2 * W_HALF;

  state_e              state_r, state_nx_s;
  logic [W_FULL-1:0]   a_r, b_r;
  logic                cin_r, carry_lo_r;
  logic [W_HALF-1:0]   add_a_s, add_b_s, add_sum_s;
  logic                add_cin_s, add_cout_s;
  logic [W_FULL-1:0]   shuma_r;
  logic                carry_out_r, overflow_r, zero_r;
  logic                in_ready_r, out_valid_r;

  // Next-state decode; DONE holds until the consumer takes the result.
  always_comb begin
    state_nx_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (IN_VALID) state_nx_s = ST_LOW;
        else          state_nx_s = ST_IDLE;
      end
      ST_LOW:  state_nx_s = ST_HIGH;
      ST_HIGH: state_nx_s = ST_DONE;
      ST_DONE: begin
        if (OUT_READY) state_nx_s = ST_IDLE;
        else           state_nx_s = ST_DONE;
      end
      default: state_nx_s = ST_IDLE;
    endcase
  end

  // Operand mux into the shared adder: upper half in HIGH, lower half otherwise.
  always_comb begin
    add_a_s   = a_r[W_HALF-1:0];
    add_b_s   = b_r[W_HALF-1:0];
    add_cin_s = cin_r;
    case (state_r)
      ST_HIGH: begin
        add_a_s   = a_r[W_FULL-1:W_HALF];
        add_b_s   = b_r[W_FULL-1:W_HALF];
        add_cin_s = carry_lo_r;
      end
      default: begin
        add_a_s   = a_r[W_HALF-1:0];
        add_b_s   = b_r[W_HALF-1:0];
        add_cin_s = cin_r;
      end
    endcase
  end

  Mbledhesi24Bitesh #(.W(W_HALF)) u_adder (
    .a    (add_a_s),
    .b    (add_b_s),
    .cin  (add_cin_s),
    .sum  (add_sum_s),
    .cout (add_cout_s)
  );

  // State, operand capture and result registers.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      a_r         <= '0;
      b_r         <= '0;
      cin_r       <= 1'b0;
      carry_lo_r  <= 1'b0;
      shuma_r     <= '0;
      carry_out_r <= 1'b0;
      overflow_r  <= 1'b0;
      zero_r      <= 1'b0;
    end else begin
      state_r     <= state_nx_s;
      in_ready_r  <= (state_nx_s == ST_IDLE);
      out_valid_r <= (state_nx_s == ST_DONE);
      case (state_r)
        ST_IDLE: begin
          // Subtract is A + ~B + ~borrow, so the adder never needs to know the op.
          if (IN_VALID) begin
            a_r   <= A;
            b_r   <= (OP == OP_SUB) ? ~B : B;
            cin_r <= (OP == OP_SUB) ? ~CIN : CIN;
          end
        end
        ST_LOW: begin
          shuma_r[W_HALF-1:0] <= add_sum_s;
          carry_lo_r          <= add_cout_s;
        end
        ST_HIGH: begin
          shuma_r[W_FULL-1:W_HALF] <= add_sum_s;
          carry_out_r              <= add_cout_s;
          overflow_r               <= ovf_bit(a_r[W_FULL-1], b_r[W_FULL-1], add_sum_s[W_HALF-1]);
          zero_r                   <= ({add_sum_s, shuma_r[W_HALF-1:0]} == '0);
        end
        default: begin
        end
      endcase
    end
  end

  assign IN_READY  = in_ready_r;
  assign OUT_VALID = out_valid_r;
  assign Shuma     = shuma_r;
  assign CarryOut  = carry_out_r;
  assign Overflow  = overflow_r;
  assign Zero      = zero_r;

endmodule

// File: tb/tb_mbledhesi_48_sekuencial.sv
// Bench for mbledhesi_48_sekuencial: transaction-level model plus directed literal checks.
module tb_mbledhesi_48_sekuencial;

  logic        CLK = 1'b0;
  logic        RST, IN_VALID, OP, CIN, OUT_READY;
  logic [47:0] A, B;
  logic        IN_READY, OUT_VALID, CarryOut, Overflow, Zero;
  logic [47:0] Shuma;

  int checks = 0;
  int failures = 0;
  bit started = 1'b0;

  mbledhesi_48_sekuencial dut (
    .CLK(CLK), .RST(RST), .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .OP(OP), .A(A), .B(B), .CIN(CIN),
    .OUT_VALID(OUT_VALID), .OUT_READY(OUT_READY),
    .Shuma(Shuma), .CarryOut(CarryOut), .Overflow(Overflow), .Zero(Zero)
  );

  always #5 CLK = ~CLK;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Reference: {carry, overflow, zero, result} from plain 49-bit arithmetic.
  function automatic logic [50:0] ref_calc(input logic op, input logic [47:0] a,
                                           input logic [47:0] b, input logic cin);
    logic [48:0] r;
    logic co, ov;
    if (!op) begin
      r  = {1'b0, a} + {1'b0, b} + {48'd0, cin};
      co = r[48];
      ov = (a[47] == b[47]) && (r[47] != a[47]);
    end else begin
      r  = {1'b0, a} - {1'b0, b} - {48'd0, cin};
      co = ~r[48];
      ov = (a[47] != b[47]) && (r[47] != a[47]);
    end
    return {co, ov, (r[47:0] == 48'd0), r[47:0]};
  endfunction

  // Model: result fixed at acceptance, visible three cycles later until taken.
  int          m_phase = 0;
  int          m_results = 0;
  logic [47:0] m_shuma = 48'd0;
  logic        m_co = 1'b0, m_ov = 1'b0, m_zero = 1'b0;

  always @(posedge CLK) begin
    if (RST) begin
      m_phase <= 0;
    end else begin
      case (m_phase)
        0: if (IN_VALID) begin
             {m_co, m_ov, m_zero, m_shuma} <= ref_calc(OP, A, B, CIN);
             m_phase <= 1;
           end
        1: m_phase <= 2;
        2: m_phase <= 3;
        3: if (OUT_READY) begin
             m_phase   <= 0;
             m_results <= m_results + 1;
           end
        default: m_phase <= 0;
      endcase
    end
  end

  always @(negedge CLK) begin
    if (started && !RST) begin
      check("in_ready", {63'd0, IN_READY}, {63'd0, (m_phase == 0)});
      check("out_valid", {63'd0, OUT_VALID}, {63'd0, (m_phase == 3)});
      if (m_phase == 3) begin
        check("shuma", {16'd0, Shuma}, {16'd0, m_shuma});
        check("carry", {63'd0, CarryOut}, {63'd0, m_co});
        check("overflow", {63'd0, Overflow}, {63'd0, m_ov});
        check("zero", {63'd0, Zero}, {63'd0, m_zero});
      end
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // Issue one request from IDLE; returns the cycle index (accept = 0) of OUT_VALID.
  task automatic run_op(input logic op, input logic [47:0] a, input logic [47:0] b,
                        input logic cin, output int cyc);
    OP = op; A = a; B = b; CIN = cin; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    A = ~a; B = ~b; OP = ~op; CIN = ~cin;
    cyc = 1;
    while (!OUT_VALID && cyc < 12) begin
      step();
      cyc++;
    end
    if (!OUT_VALID) check("timeout_out_valid", 64'd0, 64'd1);
  endtask

  logic [47:0] held;
  int cyc, r0;

  initial begin
    RST = 1'b1; IN_VALID = 1'b0; OP = 1'b0; CIN = 1'b0; OUT_READY = 1'b1;
    A = 48'd0; B = 48'd0;
    step(); step(); step();
    check("rst_in_ready", {63'd0, IN_READY}, 64'd1);
    check("rst_out_valid", {63'd0, OUT_VALID}, 64'd0);
    check("rst_flags", {61'd0, CarryOut, Overflow, Zero}, 64'd0);
    check("rst_shuma", {16'd0, Shuma}, 64'd0);
    RST = 1'b0;
    started = 1'b1;

    run_op(1'b0, 48'h000000_FFFFFF, 48'h000000_000001, 1'b0, cyc);
    check("t1_latency", cyc, 64'd3);
    check("t1_shuma", {16'd0, Shuma}, 64'h0000_000001_000000);
    check("t1_carry", {63'd0, CarryOut}, 64'd0);
    step();

    run_op(1'b0, 48'hFFFFFF_FFFFFF, 48'h000000_000001, 1'b0, cyc);
    check("t2_shuma", {16'd0, Shuma}, 64'd0);
    check("t2_flags", {61'd0, CarryOut, Overflow, Zero}, 64'b101);
    step();

    run_op(1'b1, 48'h800000_000000, 48'h000000_000001, 1'b0, cyc);
    check("t3_shuma", {16'd0, Shuma}, 64'h0000_7FFFFF_FFFFFF);
    check("t3_flags", {61'd0, CarryOut, Overflow, Zero}, 64'b110);
    step();

    // Backpressure: result must hold and new requests must be refused.
    OUT_READY = 1'b0;
    run_op(1'b0, 48'h123456_789ABC, 48'h111111_111111, 1'b1, cyc);
    check("t4_shuma", {16'd0, Shuma}, 64'h0000_234567_89ABCE);
    held = Shuma;
    OP = 1'b1; A = 48'h000000_000010; B = 48'h000000_000001; CIN = 1'b1; IN_VALID = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      check("t4_hold", {16'd0, Shuma}, {16'd0, held});
      check("t4_busy", {62'd0, IN_READY, OUT_VALID}, 64'b01);
    end
    OUT_READY = 1'b1;
    step();
    check("t4_release", {62'd0, IN_READY, OUT_VALID}, 64'b10);
    step();
    IN_VALID = 1'b0;
    cyc = 1;
    while (!OUT_VALID && cyc < 12) begin
      step();
      cyc++;
    end
    check("t4_next_latency", cyc, 64'd3);
    check("t4_next_shuma", {16'd0, Shuma}, 64'h0000_000000_00000E);
    check("t4_next_carry", {63'd0, CarryOut}, 64'd1);
    step();

    // Reset while the high half is being computed.
    OP = 1'b0; A = 48'h0000AA_000000; B = 48'h000011_000000; CIN = 1'b0; IN_VALID = 1'b1;
    step();
    IN_VALID = 1'b0;
    step();
    RST = 1'b1;
    step();
    check("t5_ready", {62'd0, IN_READY, OUT_VALID}, 64'b10);
    check("t5_outputs", {13'd0, Shuma, CarryOut, Overflow, Zero}, 64'd0);
    RST = 1'b0;
    step();

    // Back-to-back random traffic: one result every four cycles.
    r0 = m_results;
    for (int i = 0; i < 80; i++) begin
      IN_VALID = 1'b1;
      OP  = 1'($urandom_range(0, 1));
      CIN = 1'($urandom_range(0, 1));
      A   = {16'($urandom), 32'($urandom)};
      B   = {16'($urandom), 32'($urandom)};
      step();
    end
    IN_VALID = 1'b0;
    check("t6_throughput", m_results - r0, 64'd20);
    for (int i = 0; i < 6; i++) step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
